// File: rtl/prim_count_pkg.sv
// Shared types for the hardened counter and its consistency checker.
package prim_count_pkg;

    // Checker FSM encoding; 2'b11 is never entered on purpose.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ALARM = 2'b10
    } chk_state_e;

    // Actions driven into a counter in one cycle.
    typedef struct packed {
        logic clr;
        logic set;
        logic incr_en;
        logic decr_en;
        logic commit;
    } action_mask_t;

    // Map a raw state vector onto a legal state; a corrupted encoding
    // is treated as a fault and parks the checker in ALARM.
    function automatic chk_state_e legalize_state(input logic [1:0] raw);
        chk_state_e st;
        case (raw)
            2'b00:   st = IDLE;
            2'b01:   st = TRACK;
            2'b10:   st = ALARM;
            default: st = ALARM;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/prim_count_next.sv
// Next-value function of a saturating counter. Used by the counter and by
// its checker so the two can never disagree on the update rule.
module prim_count_next
    import prim_count_pkg::*;
#(
    parameter int unsigned      Width      = 2,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic [Width-1:0] i_cnt,
    input  action_mask_t     i_act,
    input  logic [Width-1:0] i_set_cnt,
    input  logic [Width-1:0] i_step,
    output logic [Width-1:0] o_cnt_next
);

    // One extra bit exposes the carry (incr overflow) and borrow (decr underflow).
    logic [Width:0] w_sum;
    logic [Width:0] w_diff;

    assign w_sum  = {1'b0, i_cnt} + {1'b0, i_step};
    assign w_diff = {1'b0, i_cnt} - {1'b0, i_step};

    // Priority clr > set > incr/decr; conflicting incr+decr holds.
    always_comb begin
        o_cnt_next = i_cnt;
        if (i_act.commit) begin
            if (i_act.clr) begin
                o_cnt_next = ResetValue;
            end else if (i_act.set) begin
                o_cnt_next = i_set_cnt;
            end else if (i_act.incr_en && !i_act.decr_en) begin
                o_cnt_next = w_sum[Width] ? {Width{1'b1}} : w_sum[Width-1:0];
            end else if (i_act.decr_en && !i_act.incr_en) begin
                o_cnt_next = w_diff[Width] ? '0 : w_diff[Width-1:0];
            end
        end
    end

endmodule

// File: rtl/prim_flop.sv
// Plain D flop with asynchronous active-low reset to a parameterised value.
module prim_flop #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_q;

    // Capture d every cycle; reset forces the configured value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= ResetValue;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/prim_count_chk.sv
// Consistency checker for a hardened up/down counter pair: sum invariant,
// shadow tracking of the primary count, sticky alarm and error-event count.
module prim_count_chk
    import prim_count_pkg::*;
#(
    parameter int unsigned      Width      = 2,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter int unsigned      ErrCntW    = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [Width-1:0]   cnt_i,
    input  logic [Width-1:0]   cnt_inv_i,
    input  logic               clr_i,
    input  logic               set_i,
    input  logic               incr_en_i,
    input  logic               decr_en_i,
    input  logic               commit_i,
    input  logic [Width-1:0]   set_cnt_i,
    input  logic [Width-1:0]   step_i,
    input  logic               err_clr_i,
    output logic               err_sum_o,
    output logic               err_track_o,
    output logic               alarm_o,
    output logic [ErrCntW-1:0] err_cnt_o,
    output logic [1:0]         state_o
);

    localparam logic [Width:0]   SumTarget = {1'b0, {Width{1'b1}}};
    localparam logic [ErrCntW-1:0] ErrCntMax = {ErrCntW{1'b1}};

    logic [1:0]         r_state_raw;
    chk_state_e         w_state;
    chk_state_e         w_state_next;
    logic [Width-1:0]   r_exp;
    logic [Width-1:0]   w_exp_base;
    logic [Width-1:0]   w_exp_next;
    logic [2:0]         r_flags;
    logic [2:0]         w_flags_next;
    logic [ErrCntW-1:0] r_err_cnt;
    logic [ErrCntW-1:0] w_err_cnt_next;
    action_mask_t       w_act;
    logic [Width:0]     w_pair_sum;
    logic               w_sum_err;
    logic               w_track_err;
    logic               w_any_err;

    assign w_state = legalize_state(r_state_raw);
    assign w_act   = {clr_i, set_i, incr_en_i, decr_en_i, commit_i};

    // Only TRACK advances the shadow from its own value. Everywhere else the
    // shadow is resynced from the live count, with this cycle's action applied
    // so the first compared sample already reflects it.
    assign w_exp_base = (w_state == TRACK) ? r_exp : cnt_i;

    prim_count_next #(
        .Width     (Width),
        .ResetValue(ResetValue)
    ) u_next (
        .i_cnt     (w_exp_base),
        .i_act     (w_act),
        .i_set_cnt (set_cnt_i),
        .i_step    (step_i),
        .o_cnt_next(w_exp_next)
    );

    // The shadow is meaningless once the alarm fires, so tracking is only
    // judged in TRACK; the pair invariant stays watched in ALARM.
    assign w_pair_sum  = {1'b0, cnt_i} + {1'b0, cnt_inv_i};
    assign w_sum_err   = (w_state != IDLE) && (w_pair_sum != SumTarget);
    assign w_track_err = (w_state == TRACK) && (cnt_i != r_exp);
    assign w_any_err   = w_sum_err | w_track_err;

    // Next-state selection; a mismatch always beats an alarm clear.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            IDLE: begin
                if (en_i) w_state_next = TRACK;
            end
            TRACK: begin
                if (w_any_err)  w_state_next = ALARM;
                else if (!en_i) w_state_next = IDLE;
            end
            ALARM: begin
                if (err_clr_i && !w_any_err) w_state_next = en_i ? TRACK : IDLE;
            end
            default: w_state_next = ALARM;
        endcase
    end

    // Per-cycle flags and the alarm, all registered one cycle after the sample.
    always_comb begin
        w_flags_next   = {w_sum_err, w_track_err, (w_state_next == ALARM)};
        w_err_cnt_next = r_err_cnt;
        if (w_any_err && (r_err_cnt != ErrCntMax)) begin
            w_err_cnt_next = r_err_cnt + ErrCntW'(1);
        end
    end

    prim_flop #(.Width(2), .ResetValue(IDLE)) u_state_flop (
        .i_clk(clk_i), .i_rst_n(rst_ni), .i_d(w_state_next), .o_q(r_state_raw)
    );

    prim_flop #(.Width(Width), .ResetValue(ResetValue)) u_exp_flop (
        .i_clk(clk_i), .i_rst_n(rst_ni), .i_d(w_exp_next), .o_q(r_exp)
    );

    prim_flop #(.Width(3), .ResetValue(3'b000)) u_flags_flop (
        .i_clk(clk_i), .i_rst_n(rst_ni), .i_d(w_flags_next), .o_q(r_flags)
    );

    prim_flop #(.Width(ErrCntW), .ResetValue('0)) u_err_cnt_flop (
        .i_clk(clk_i), .i_rst_n(rst_ni), .i_d(w_err_cnt_next), .o_q(r_err_cnt)
    );

    assign err_sum_o   = r_flags[2];
    assign err_track_o = r_flags[1];
    assign alarm_o     = r_flags[0];
    assign err_cnt_o   = r_err_cnt;
    assign state_o     = w_state;

endmodule

// File: tb/tb_prim_count_chk.sv
// Directed-vector bench for prim_count_chk (Width=4, ResetValue=0, ErrCntW=4).
module tb_prim_count_chk;

    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] SA = 2'b10;
    localparam int NV = 38;

    typedef struct {
        logic       en;
        logic [3:0] cnt;
        logic [3:0] inv;
        logic       clr;
        logic       set;
        logic       incr;
        logic       decr;
        logic       commit;
        logic [3:0] setv;
        logic [3:0] step;
        logic       eclr;
        logic       e_sum;
        logic       e_trk;
        logic       e_alarm;
        logic [3:0] e_cnt;
        logic [1:0] e_state;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, set, incr, decr, commit, eclr;
    logic [3:0] cnt, inv, setv, step;
    logic       err_sum, err_track, alarm;
    logic [3:0] err_cnt;
    logic [1:0] state;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    prim_count_chk #(
        .Width     (4),
        .ResetValue(4'd0),
        .ErrCntW   (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .cnt_i      (cnt),
        .cnt_inv_i  (inv),
        .clr_i      (clr),
        .set_i      (set),
        .incr_en_i  (incr),
        .decr_en_i  (decr),
        .commit_i   (commit),
        .set_cnt_i  (setv),
        .step_i     (step),
        .err_clr_i  (eclr),
        .err_sum_o  (err_sum),
        .err_track_o(err_track),
        .alarm_o    (alarm),
        .err_cnt_o  (err_cnt),
        .state_o    (state)
    );

    function automatic vec_t v(input logic a_en, input int a_cnt, input int a_inv,
                               input logic a_clr, input logic a_set, input logic a_inc,
                               input logic a_dec, input logic a_com, input int a_setv,
                               input int a_step, input logic a_eclr, input logic x_sum,
                               input logic x_trk, input logic x_alarm, input int x_cnt,
                               input logic [1:0] x_state);
        vec_t r;
        r.en = a_en; r.cnt = 4'(a_cnt); r.inv = 4'(a_inv);
        r.clr = a_clr; r.set = a_set; r.incr = a_inc; r.decr = a_dec; r.commit = a_com;
        r.setv = 4'(a_setv); r.step = 4'(a_step); r.eclr = a_eclr;
        r.e_sum = x_sum; r.e_trk = x_trk; r.e_alarm = x_alarm;
        r.e_cnt = 4'(x_cnt); r.e_state = x_state;
        return r;
    endfunction

    task automatic set_in(input logic a_en, input int a_cnt, input int a_inv,
                          input logic a_clr, input logic a_set, input logic a_inc,
                          input logic a_dec, input logic a_com, input int a_setv,
                          input int a_step, input logic a_eclr);
        en = a_en; cnt = 4'(a_cnt); inv = 4'(a_inv);
        clr = a_clr; set = a_set; incr = a_inc; decr = a_dec; commit = a_com;
        setv = 4'(a_setv); step = 4'(a_step); eclr = a_eclr;
    endtask

    task automatic check(input string tag, input logic x_sum, input logic x_trk,
                         input logic x_alarm, input int x_cnt, input logic [1:0] x_state);
        n_vec++;
        $display("%s: state=%0d sum=%0d trk=%0d alarm=%0d err_cnt=%0d",
                 tag, state, err_sum, err_track, alarm, err_cnt);
        if (err_sum !== x_sum) begin
            n_bad++;
            $display("FAIL %s.err_sum: got %0b, want %0b", tag, err_sum, x_sum);
        end
        if (err_track !== x_trk) begin
            n_bad++;
            $display("FAIL %s.err_track: got %0b, want %0b", tag, err_track, x_trk);
        end
        if (alarm !== x_alarm) begin
            n_bad++;
            $display("FAIL %s.alarm: got %0b, want %0b", tag, alarm, x_alarm);
        end
        if (err_cnt !== 4'(x_cnt)) begin
            n_bad++;
            $display("FAIL %s.err_cnt: got %0d, want %0d", tag, err_cnt, x_cnt);
        end
        if (state !== x_state) begin
            n_bad++;
            $display("FAIL %s.state: got %0d, want %0d", tag, state, x_state);
        end
    endtask

    task automatic tick_check(input string tag, input logic x_sum, input logic x_trk,
                              input logic x_alarm, input int x_cnt, input logic [1:0] x_state);
        @(posedge clk);
        #1;
        check(tag, x_sum, x_trk, x_alarm, x_cnt, x_state);
    endtask

    initial begin
        // Each record: inputs for one cycle, expected outputs after that edge.
        //               en cnt inv clr set inc dec com setv step eclr | sum trk alm ecnt state
        vecs[0]  = v(0,  0, 15, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, SI);
        vecs[1]  = v(1,  0, 15, 0, 0, 1, 0, 1, 0, 3, 0,  0, 0, 0, 0, ST);
        vecs[2]  = v(1,  3, 12, 0, 0, 1, 0, 1, 0, 3, 0,  0, 0, 0, 0, ST);
        vecs[3]  = v(1,  6,  9, 0, 0, 1, 0, 1, 0, 3, 0,  0, 0, 0, 0, ST);
        vecs[4]  = v(1,  9,  6, 0, 0, 1, 0, 1, 0, 3, 0,  0, 0, 0, 0, ST);
        vecs[5]  = v(1, 12,  3, 0, 0, 1, 0, 1, 0, 3, 0,  0, 0, 0, 0, ST);
        vecs[6]  = v(1, 15,  0, 0, 0, 1, 0, 1, 0, 3, 0,  0, 0, 0, 0, ST);
        vecs[7]  = v(1, 15,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, ST);
        vecs[8]  = v(1, 15,  0, 0, 1, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, ST);
        vecs[9]  = v(1,  5, 10, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, ST);
        vecs[10] = v(1,  5,  9, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, SA);
        vecs[11] = v(1,  5, 10, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, SA);
        vecs[12] = v(1,  5, 10, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, ST);
        vecs[13] = v(1,  5, 10, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, ST);
        vecs[14] = v(1,  7,  8, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 2, SA);
        vecs[15] = v(1,  7,  8, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, SA);
        vecs[16] = v(1,  7,  8, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 2, ST);
        vecs[17] = v(1,  7,  8, 0, 0, 1, 0, 1, 0, 1, 0,  0, 0, 0, 2, ST);
        vecs[18] = v(1,  8,  7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, ST);
        vecs[19] = v(1,  8,  6, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 3, SA);
        vecs[20] = v(1,  8,  6, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 4, SA);
        vecs[21] = v(1,  8,  7, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 4, ST);
        vecs[22] = v(1,  8,  7, 0, 0, 1, 1, 1, 0, 1, 0,  0, 0, 0, 4, ST);
        vecs[23] = v(1,  8,  7, 1, 1, 0, 0, 1, 9, 0, 0,  0, 0, 0, 4, ST);
        vecs[24] = v(1,  0, 15, 0, 0, 1, 0, 0, 0, 2, 0,  0, 0, 0, 4, ST);
        vecs[25] = v(1,  0, 15, 0, 0, 0, 1, 1, 0, 3, 0,  0, 0, 0, 4, ST);
        vecs[26] = v(1,  0, 15, 0, 0, 1, 0, 1, 0, 2, 0,  0, 0, 0, 4, ST);
        vecs[27] = v(1,  2, 13, 0, 0, 0, 1, 1, 0, 1, 0,  0, 0, 0, 4, ST);
        vecs[28] = v(1,  1, 14, 0, 0, 0, 1, 1, 0, 5, 0,  0, 0, 0, 4, ST);
        vecs[29] = v(1,  0, 15, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, ST);
        vecs[30] = v(0,  0, 15, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, SI);
        vecs[31] = v(0,  6,  5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, SI);
        vecs[32] = v(0,  9,  6, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, SI);
        vecs[33] = v(1,  9,  6, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, ST);
        vecs[34] = v(1,  9,  6, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, ST);
        vecs[35] = v(1, 10,  6, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 5, SA);
        vecs[36] = v(0,  9,  6, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 5, SA);
        vecs[37] = v(0,  9,  6, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 5, SI);

        // Power-on reset.
        rst_n = 1'b0;
        set_in(0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0, SI);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: tracking, sum/track errors, clear, simultaneous actions, en handling.
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].en, int'(vecs[i].cnt), int'(vecs[i].inv), vecs[i].clr,
                   vecs[i].set, vecs[i].incr, vecs[i].decr, vecs[i].commit,
                   int'(vecs[i].setv), int'(vecs[i].step), vecs[i].eclr);
            tick_check($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_trk,
                       vecs[i].e_alarm, int'(vecs[i].e_cnt), vecs[i].e_state);
        end

        // Clear the error counter left by the table with an async reset pulse.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pulse", 0, 0, 0, 0, SI);
        @(negedge clk);
        rst_n = 1'b1;

        // Build up to ALARM with err_cnt=3.
        set_in(1, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_check("pre_track", 0, 0, 0, 0, ST);
        set_in(1, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_check("pre_err1", 1, 0, 1, 1, SA);
        tick_check("pre_err2", 1, 0, 1, 2, SA);
        tick_check("pre_err3", 1, 0, 1, 3, SA);

        // Mid-cycle asynchronous reset while in ALARM.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_alarm", 0, 0, 0, 0, SI);
        @(negedge clk);
        rst_n = 1'b1;

        // Bad pair with en low: no checking until enabled.
        set_in(0, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_check("post_rst_idle0", 0, 0, 0, 0, SI);
        tick_check("post_rst_idle1", 0, 0, 0, 0, SI);
        set_in(1, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_check("resume_track", 0, 0, 0, 0, ST);

        // Error counter saturates at 15.
        set_in(1, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            tick_check($sformatf("sat%0d", k), 1, 0, 1, (k > 15) ? 15 : k, SA);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
